mag_stats: RTL

MAG_STATS -- requirements
Module: mag_stats

---
 rtl/mag_stats.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mag_stats.sv
// mag_stats: running statistics over a stream of 8-bit magnitude samples.
//
// Each accepted sample walks IDLE -> ACCUM -> EMIT. The record is held on the
// outputs until downstream takes it. The next sample is accepted on the edge
// after that handshake, so samples are at least three cycles apart.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/in_ready    sample handshake; in_data is the sample
//   thresh               crossing threshold, captured together with the sample
//   clear                synchronous clear of all statistics (honoured in IDLE only)
//   out_valid/out_ready  record handshake
//   out_max, out_min     extremes since reset or clear
//   out_avg              mean of the last four samples (0 when averaging is not built)
//   out_cross            upward threshold crossings, saturating at 255
//   out_count            samples accepted, saturating at 65535
//
// Build option
//   MAG_STATS_AVG_EN  when defined, includes the 4-entry window, the running sum
//                     and the average output. Otherwise out_avg is tied to zero.
//
// state | meaning
// IDLE  | waiting for a sample or a clear
// ACCUM | fold the captured sample into the statistics
// EMIT  | record valid, waiting for out_ready
module mag_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [7:0]  thresh,
  input  logic        clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_max,
  output logic [7:0]  out_min,
  output logic [7:0]  out_avg,
  output logic [7:0]  out_cross,
  output logic [15:0] out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  samp_q;
  logic [7:0]  thr_q;
  logic        prev_above_q;
  logic        out_valid_q;
  logic [7:0]  max_q;
  logic [7:0]  min_q;
  logic [7:0]  cross_q;
  logic [15:0] count_q;

  logic        above_d;
  logic [7:0]  max_d;
  logic [7:0]  min_d;
  logic [7:0]  cross_d;
  logic [15:0] count_d;

`ifdef MAG_STATS_AVG_EN
  // win_q[0] is the newest sample. The sum tracks the window contents, so the
  // oldest entry leaves the sum as the new sample enters.
  logic [3:0][7:0] win_q;
  logic [9:0]      sum_q;
  logic [7:0]      avg_q;
  logic [9:0]      sum_d;
`endif

  assign in_ready = (state_q == IDLE) && !clear;

  always_comb begin
    above_d = samp_q > thr_q;
    max_d   = (samp_q > max_q) ? samp_q : max_q;
    min_d   = (samp_q < min_q) ? samp_q : min_q;
    cross_d = cross_q;
    if (above_d && !prev_above_q && (cross_q != 8'hFF)) begin
      cross_d = cross_q + 8'd1;
    end
    count_d = (count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
`ifdef MAG_STATS_AVG_EN
    sum_d = sum_q - {2'b00, win_q[3]} + {2'b00, samp_q};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      samp_q       <= 8'd0;
      thr_q        <= 8'd0;
      prev_above_q <= 1'b0;
      out_valid_q  <= 1'b0;
      max_q        <= 8'h00;
      min_q        <= 8'hFF;
      cross_q      <= 8'd0;
      count_q      <= 16'd0;
`ifdef MAG_STATS_AVG_EN
      win_q        <= '0;
      sum_q        <= 10'd0;
      avg_q        <= 8'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // clear has priority: in_ready is low whenever clear is high
          if (clear) begin
            prev_above_q <= 1'b0;
            max_q        <= 8'h00;
            min_q        <= 8'hFF;
            cross_q      <= 8'd0;
            count_q      <= 16'd0;
`ifdef MAG_STATS_AVG_EN
            win_q        <= '0;
            sum_q        <= 10'd0;
            avg_q        <= 8'd0;
`endif
          end else if (in_valid) begin
            samp_q  <= in_data;
            thr_q   <= thresh;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          prev_above_q <= above_d;
          max_q        <= max_d;
          min_q        <= min_d;
          cross_q      <= cross_d;
          count_q      <= count_d;
`ifdef MAG_STATS_AVG_EN
          win_q        <= {win_q[2:0], samp_q};
          sum_q        <= sum_d;
          avg_q        <= sum_d[9:2];
`endif
          out_valid_q  <= 1'b1;
          state_q      <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_max   = max_q;
  assign out_min   = min_q;
  assign out_cross = cross_q;
  assign out_count = count_q;
`ifdef MAG_STATS_AVG_EN
  assign out_avg   = avg_q;
`else
  assign out_avg   = 8'd0;
`endif

endmodule
